// File: rtl/ex_muldiv_unit_if.sv
// ============================================================================
//  ex_muldiv_unit_if : ID/EX-side handshake and result bus of the M-extension unit
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ex_muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  flush_i;
   logic                  start_i;
   logic [2:0]            funct3_i;
   logic [DATA_WIDTH-1:0] op_a_i;
   logic [DATA_WIDTH-1:0] op_b_i;
   logic                  stall_o;
   logic                  busy_o;
   logic                  valid_o;
   logic [DATA_WIDTH-1:0] result_o;

   modport master (
      output flush_i, start_i, funct3_i, op_a_i, op_b_i,
      input  stall_o, busy_o, valid_o, result_o
   );

   modport slave (
      input  flush_i, start_i, funct3_i, op_a_i, op_b_i,
      output stall_o, busy_o, valid_o, result_o
   );
endinterface

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  ex_muldiv_unit : radix-2 iterative RV32M multiply/divide engine for EX stage
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   ex_muldiv_unit_if.slave  bus
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam int DW = DATA_WIDTH;
   localparam logic [CW-1:0] c_last_iter = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] c_cnt_one   = CW'(1);
   localparam logic [DW-1:0] c_int_min   = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_funct3;
   logic            r_neg;
   logic            r_neg_rem;
   logic [2*DW-1:0] r_mcand;
   logic [2*DW-1:0] r_acc;
   logic [DW-1:0]   r_opb;
   logic [DW-1:0]   r_rem;
   logic [DW-1:0]   r_quo;
   logic [DW-1:0]   r_result;

   // ---------------------------------------------------------------- decode
   logic          w_is_div;
   logic          w_a_signed;
   logic          w_b_signed;
   logic          w_sign_a;
   logic          w_sign_b;
   logic [DW-1:0] w_abs_a;
   logic [DW-1:0] w_abs_b;
   logic          w_div_zero;
   logic          w_div_ovf;
   logic          w_fast;
   logic [DW-1:0] w_fast_res;
   logic          w_accept;

   assign w_is_div   = bus.funct3_i[2];
   assign w_a_signed = w_is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
   assign w_b_signed = w_is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
   assign w_sign_a   = w_a_signed & bus.op_a_i[DW-1];
   assign w_sign_b   = w_b_signed & bus.op_b_i[DW-1];
   assign w_abs_a    = w_sign_a ? -bus.op_a_i : bus.op_a_i;
   assign w_abs_b    = w_sign_b ? -bus.op_b_i : bus.op_b_i;

   // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely
   assign w_div_zero = w_is_div & (bus.op_b_i == '0);
   assign w_div_ovf  = w_is_div & ~bus.funct3_i[0] &
                       (bus.op_a_i == c_int_min) & (bus.op_b_i == '1);
   assign w_fast     = w_div_zero | w_div_ovf;
   assign w_fast_res = w_div_zero ? (bus.funct3_i[1] ? bus.op_a_i : '1)
                                  : (bus.funct3_i[1] ? '0 : c_int_min);

   assign w_accept   = (r_state == ST_IDLE) & bus.start_i & ~bus.flush_i;

   // ------------------------------------------------------------- iteration
   logic [2*DW-1:0] w_acc_nx;
   logic [DW:0]     w_rem_sh;
   logic [DW:0]     w_diff;
   logic            w_ge;
   logic [DW-1:0]   w_rem_nx;
   logic [DW-1:0]   w_quo_nx;
   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_quo_fin;
   logic [DW-1:0]   w_rem_fin;
   logic [DW-1:0]   w_calc_res;

   assign w_acc_nx  = r_acc + (r_opb[r_cnt] ? r_mcand : '0);
   assign w_rem_sh  = {r_rem, r_quo[DW-1]};
   assign w_diff    = w_rem_sh - {1'b0, r_opb};
   assign w_ge      = ~w_diff[DW];
   assign w_rem_nx  = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
   assign w_quo_nx  = {r_quo[DW-2:0], w_ge};

   // Final-iteration values are sign-corrected on the way into r_result
   assign w_prod    = r_neg ? -w_acc_nx : w_acc_nx;
   assign w_quo_fin = r_neg ? -w_quo_nx : w_quo_nx;
   assign w_rem_fin = r_neg_rem ? -w_rem_nx : w_rem_nx;
   assign w_calc_res = r_funct3[2] ? (r_funct3[1] ? w_rem_fin : w_quo_fin)
                                   : ((r_funct3[1:0] == 2'b00) ? w_prod[DW-1:0]
                                                               : w_prod[2*DW-1:DW]);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = w_fast ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == c_last_iter) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
      if (bus.flush_i) begin
         w_next = ST_IDLE;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_neg     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_result  <= '0;
      end else if (w_accept) begin
         r_cnt     <= '0;
         r_funct3  <= bus.funct3_i;
         r_neg     <= w_sign_a ^ w_sign_b;
         r_neg_rem <= w_sign_a;
         r_mcand   <= {{DW{1'b0}}, w_abs_a};
         r_acc     <= '0;
         r_opb     <= w_abs_b;
         r_rem     <= '0;
         r_quo     <= w_abs_a;
         if (w_fast) begin
            r_result <= w_fast_res;
         end
      end else if (bus.flush_i) begin
         r_cnt <= '0;
      end else if (r_state == ST_CALC) begin
         r_cnt <= r_cnt + c_cnt_one;
         if (r_funct3[2]) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
         end else begin
            r_acc   <= w_acc_nx;
            r_mcand <= r_mcand << 1;
         end
         if (r_cnt == c_last_iter) begin
            r_result <= w_calc_res;
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.stall_o  = rst_n & ~bus.flush_i &
                         (((r_state == ST_IDLE) & bus.start_i) | (r_state == ST_CALC));
   assign bus.busy_o   = (r_state == ST_CALC);
   assign bus.valid_o  = (r_state == ST_DONE);
   assign bus.result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
//  tb_ex_muldiv_unit : randomized self-checking bench against a cycle-level reference
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ex_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0];  end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int op_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // m_wait counts cycles left until the result cycle; m_active marks an accepted op
   bit          m_active  = 1'b0;
   int          m_wait    = 0;
   logic [31:0] m_pend    = '0;
   logic [31:0] m_res_out = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active  <= 1'b0;
         m_wait    <= 0;
         m_res_out <= '0;
      end else if (bus.flush_i) begin
         m_active <= 1'b0;
      end else if (m_active) begin
         if (m_wait == 0) begin
            m_active <= 1'b0;
         end else begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_res_out <= m_pend;
         end
      end else if (bus.start_i) begin
         m_active <= 1'b1;
         m_pend   <= ref_result(bus.funct3_i, bus.op_a_i, bus.op_b_i);
         m_wait   <= op_latency(bus.funct3_i, bus.op_a_i, bus.op_b_i) - 1;
         if (op_latency(bus.funct3_i, bus.op_a_i, bus.op_b_i) == 1)
            m_res_out <= ref_result(bus.funct3_i, bus.op_a_i, bus.op_b_i);
      end
   end

   always @(negedge clk) begin
      check("valid", 32'(bus.valid_o), 32'(m_active && m_wait == 0));
      check("busy",  32'(bus.busy_o),  32'(m_active && m_wait != 0));
      check("stall", 32'(bus.stall_o),
            32'(rst_n && !bus.flush_i &&
                ((!m_active && bus.start_i) || (m_active && m_wait != 0))));
      check("result", bus.result_o, m_res_out);
   end

   // ------------------------------------------------------------- stimulus
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input bit use_lit, input logic [31:0] lit);
      int          lat;
      int          got;
      logic [31:0] res;
      lat = op_latency(f3, a, b);
      got = -1;
      res = '0;
      bus.start_i  = 1'b1;
      bus.flush_i  = 1'b0;
      bus.funct3_i = f3;
      bus.op_a_i   = a;
      bus.op_b_i   = b;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         bus.flush_i  = (k == flush_at);
         bus.start_i  = (k == flush_at) ? 1'b0 : 1'($urandom_range(0, 1));
         bus.funct3_i = 3'($urandom);
         bus.op_a_i   = $urandom;
         bus.op_b_i   = $urandom;
         if (k == flush_at) begin
            #1 check("flush_stall", 32'(bus.stall_o), 32'd0);
         end
         if (bus.valid_o) begin
            got = k;
            res = bus.result_o;
            break;
         end
         if (k == flush_at) break;
      end
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;
      if (flush_at < 1 || flush_at >= lat) begin
         check("latency", 32'(got), 32'(lat));
         if (use_lit) check("literal", res, lit);
      end else begin
         check("flushed_no_valid", 32'(got), 32'hFFFF_FFFF);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_i  = 1'b0;
      bus.flush_i  = 1'b0;
      bus.funct3_i = '0;
      bus.op_a_i   = '0;
      bus.op_b_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid",  32'(bus.valid_o), 32'd0);
      check("rst_busy",   32'(bus.busy_o),  32'd0);
      check("rst_result", bus.result_o,     32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(3'b000, 32'd7,         32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFEB);
      do_op(3'b001, 32'd7,         32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFFF);
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFE);
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFF);
      do_op(3'b100, 32'hFFFF_FFEC, 32'd3,         -1, 1'b1, 32'hFFFF_FFFA);
      do_op(3'b110, 32'hFFFF_FFEC, 32'd3,         -1, 1'b1, 32'hFFFF_FFFE);
      do_op(3'b101, 32'd100,       32'd7,         -1, 1'b1, 32'd14);
      do_op(3'b111, 32'd100,       32'd7,         -1, 1'b1, 32'd2);
      do_op(3'b100, 32'd5,         32'd0,         -1, 1'b1, 32'hFFFF_FFFF);
      do_op(3'b111, 32'd5,         32'd0,         -1, 1'b1, 32'd5);
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h8000_0000);
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'd0);

      // Flush a DIV mid-flight, then start a MUL two cycles after the flush
      do_op(3'b100, 32'hFFFF_FFEC, 32'd3, 10, 1'b0, 32'd0);
      @(posedge clk); #1;
      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, -1, 1'b1, 32'hFFFF_FFEB);

      // Reset in the middle of a MUL
      bus.start_i  = 1'b1;
      bus.funct3_i = 3'b000;
      bus.op_a_i   = 32'd123;
      bus.op_b_i   = 32'd456;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy",   32'(bus.busy_o),  32'd0);
      check("midrst_stall",  32'(bus.stall_o), 32'd0);
      check("midrst_valid",  32'(bus.valid_o), 32'd0);
      check("midrst_result", bus.result_o,     32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rel_busy",   32'(bus.busy_o),  32'd0);
      check("rel_stall",  32'(bus.stall_o), 32'd0);
      check("rel_valid",  32'(bus.valid_o), 32'd0);
      check("rel_result", bus.result_o,     32'd0);
      repeat (40) @(posedge clk);
      #1;
      do_op(3'b101, 32'd9, 32'd2, -1, 1'b1, 32'd4);

      // Randomized traffic, with occasional flushes and refused start+flush cycles
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int          fl;
         f3 = 3'($urandom);
         a  = pick_operand();
         b  = pick_operand();
         fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 34)) : -1;
         if ($urandom_range(0, 9) == 0) begin
            bus.start_i  = 1'b1;
            bus.flush_i  = 1'b1;
            bus.funct3_i = f3;
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
            @(posedge clk); #1;
         end
         do_op(f3, a, b, fl, 1'b0, 32'd0);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
